rand_range_gen: RTL
===================

// Module: rand_range_gen
// PURPOSE
//  Parametrised LFSR random source with a request/valid handshake and bounded output.
//  Returns a uniform value in [0, limit-1] by rejection sampling; optionally never repeats the last value.
//  Feeds the mole-game controller, which picks the next hole index.
//  Supports run-time reseed and recovers automatically from LFSR lock-up.
// PARAMETERS
//  LFSR_W    16        LFSR width (>=OUT_W, >=SEED_W)
//  TAPS      16'hB400  Fibonacci feedback mask (bits 15,13,12,10)
//  SEED_W    9         seed port width
//  OUT_W     4         result width
//  NO_REPEAT 1         1: a result never equals the previous result when limit != 1
//  MAX_TRIES 8         rejection attempts before deterministic fallback (>=1)
// PORTS
//  clk_1mhz   in   1        system clock
//  rst        in   1        synchronous active-high reset
//  seed       in   SEED_W   seed, loaded on rst or reseed
//  reseed     in   1        load seed into LFSR; aborts any draw in progress
//  req        in   1        request one result (taken only when busy=0)
//  limit      in   OUT_W    exclusive upper bound, captured on request; 0 = full 2^OUT_W range
//  rand_num   out  OUT_W    last accepted result; held until the next accept
//  rand_valid out  1        1-cycle pulse when rand_num updates
//  busy       out  1        high while a draw is in progress
//  lfsr_out   out  LFSR_W   current LFSR state (debug/verification)
// BEHAVIOUR
//  - Seed load (rst or reseed): lfsr <= zero-extended seed. A zero seed loads 1.
//  - LFSR step: free-runs every cycle when no seed load occurs.
//    next = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)}.
//    If the state is ever all-zero, it is forced to 1 on the next cycle.
//  - Reset values: rand_num=0, rand_valid=0, busy=0, last=0, state=IDLE, tries=0.
//  - FSM states: IDLE and DRAW.
//    IDLE: req=1 -> DRAW. lim_q <= limit, tries <= 0. Otherwise stay in IDLE.
//    DRAW: each cycle, cand = lfsr[OUT_W-1:0] (current state).
//          Accept if (lim_q==0 || cand<lim_q) and (!NO_REPEAT || lim_q==1 || cand!=last).
//          Accept -> rand_num<=cand, last<=cand, rand_valid<=1, IDLE.
//          Reject with tries<MAX_TRIES-1 -> tries++, stay in DRAW.
//          Reject with tries==MAX_TRIES-1 -> emit fallback, IDLE.
//  - Fallback value:
//    * NO_REPEAT=1 and lim_q!=1: last+1, wrapping to 0 when last+1 >= lim_q
//      (lim_q==0 wraps naturally at 2^OUT_W).
//    * Otherwise: 0.
//  - Latency: req seen in IDLE at cycle T -> rand_valid at T+2 at the earliest,
//    T+1+MAX_TRIES at the latest.
//  - busy = (state==DRAW); it is registered and rises at T+1.
//  - req while busy=1 is ignored (not queued). req held high re-requests
//    in the cycle after rand_valid.
//  - reseed takes priority over everything. It loads the seed, sets state to IDLE,
//    tries to 0, gives no rand_valid for the aborted draw, and keeps rand_num and last.
//  - limit changes during DRAW have no effect; only lim_q is used.
//  - rst takes priority over reseed and req.
// TESTING
//  1. rst with seed=9'h001, then idle -> lfsr_out = 16'h0001, 16'h0002, ... 16'h0400 at cycle 10,
//     16'h0801 at cycle 11.
//  2. rst with seed=0 -> lfsr_out=16'h0001 after reset. Force lfsr to 0 -> 16'h0001 next cycle.
//  3. limit=9, NO_REPEAT=1, 2000 back-to-back reqs -> every rand_num <9, no two consecutive equal,
//     all 0..8 seen, each rand_valid 2..MAX_TRIES+1 cycles after its req.
//  4. limit=1 -> rand_num=0 with rand_valid at T+2 after the first DRAW cycle accepts
//     (any cand with low bits 0) or via fallback 0; never hangs.
//  5. MAX_TRIES=1, last=3, limit=4, cand rejected -> rand_num=0 (wrap), rand_valid at T+2.
//  6. reseed at T+1 of a draw -> busy=0 at T+2, no rand_valid, rand_num unchanged,
//     lfsr_out = new seed. req during busy -> ignored.

Source files
------------

// File: rtl/rand_range_gen_if.sv
// Handshake, seed and debug signals of the bounded random source.
interface rand_range_gen_if #(
    parameter int LFSR_W = 16,
    parameter int SEED_W = 9,
    parameter int OUT_W  = 4
);
    logic [SEED_W-1:0] seed;
    logic              reseed;
    logic              req;
    logic [OUT_W-1:0]  limit;
    logic [OUT_W-1:0]  rand_num;
    logic              rand_valid;
    logic              busy;
    logic [LFSR_W-1:0] lfsr_out;

    modport slave (
        input  seed, reseed, req, limit,
        output rand_num, rand_valid, busy, lfsr_out
    );

    modport master (
        output seed, reseed, req, limit,
        input  rand_num, rand_valid, busy, lfsr_out
    );
endinterface

// File: rtl/rand_range_gen.sv
// Free-running Fibonacci LFSR with a request/valid draw FSM that returns a value in [0, limit-1]
// by rejection sampling, falling back to a deterministic value after MAX_TRIES rejections.
module rand_range_gen #(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
    parameter int                SEED_W    = 9,
    parameter int                OUT_W     = 4,
    parameter int                NO_REPEAT = 1,
    parameter int                MAX_TRIES = 8
) (
    input  logic            clk_1mhz,
    input  logic            rst,
    rand_range_gen_if.slave bus
);
    localparam int              TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [OUT_W-1:0]   lim_q, lim_d;
    logic [OUT_W-1:0]   last_q, last_d;
    logic [OUT_W-1:0]   num_q, num_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic [LFSR_W-1:0]  seed_load_s;
    logic [OUT_W-1:0]   cand_s;
    logic               in_range_s;
    logic               fresh_s;
    logic               accept_s;

    // Successor of the last result, wrapped into [0, lim-1]; 0 when no-repeat does not apply.
    function automatic logic [OUT_W-1:0] fallback_value(input logic [OUT_W-1:0] last,
                                                        input logic [OUT_W-1:0] lim);
        logic [OUT_W:0] inc;
        inc = {1'b0, last} + {{OUT_W{1'b0}}, 1'b1};
        if ((NO_REPEAT != 0) && (lim != OUT_W'(1))) begin
            if ((lim != {OUT_W{1'b0}}) && (inc >= {1'b0, lim})) begin
                fallback_value = {OUT_W{1'b0}};
            end else begin
                fallback_value = inc[OUT_W-1:0];
            end
        end else begin
            fallback_value = {OUT_W{1'b0}};
        end
    endfunction

    // Seed load value and LFSR step with all-zero lock-up recovery.
    always_comb begin
        if (bus.seed == {SEED_W{1'b0}}) begin
            seed_load_s = LFSR_W'(1);
        end else begin
            seed_load_s = LFSR_W'(bus.seed);
        end
        if (bus.reseed) begin
            lfsr_d = seed_load_s;
        end else if (lfsr_q == {LFSR_W{1'b0}}) begin
            lfsr_d = LFSR_W'(1);
        end else begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
        end
    end

    // Acceptance test for the current candidate.
    always_comb begin
        cand_s     = lfsr_q[OUT_W-1:0];
        in_range_s = (lim_q == {OUT_W{1'b0}}) || (cand_s < lim_q);
        fresh_s    = (NO_REPEAT == 0) || (lim_q == OUT_W'(1)) || (cand_s != last_q);
        accept_s   = in_range_s && fresh_s;
    end

    // Draw FSM next-state and result logic; reseed aborts a draw silently.
    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        lim_d   = lim_q;
        last_d  = last_q;
        num_d   = num_q;
        valid_d = 1'b0;
        if (bus.reseed) begin
            state_d = IDLE;
            tries_d = {TRY_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        state_d = DRAW;
                        lim_d   = bus.limit;
                        tries_d = {TRY_W{1'b0}};
                    end else begin
                        state_d = IDLE;
                    end
                end
                DRAW: begin
                    if (accept_s) begin
                        num_d   = cand_s;
                        last_d  = cand_s;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else if (tries_q == LAST_TRY) begin
                        num_d   = fallback_value(last_q, lim_q);
                        last_d  = fallback_value(last_q, lim_q);
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tries_d = tries_q + TRY_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    tries_d = {TRY_W{1'b0}};
                end
            endcase
        end
        busy_d = (state_d == DRAW);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            lfsr_q  <= seed_load_s;
            state_q <= IDLE;
            tries_q <= {TRY_W{1'b0}};
            lim_q   <= {OUT_W{1'b0}};
            last_q  <= {OUT_W{1'b0}};
            num_q   <= {OUT_W{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            state_q <= state_d;
            tries_q <= tries_d;
            lim_q   <= lim_d;
            last_q  <= last_d;
            num_q   <= num_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.rand_num   = num_q;
    assign bus.rand_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.lfsr_out   = lfsr_q;
endmodule
